huff_pair_encoder: RTL and testbench

HUFF_PAIR_ENCODER -- requirements
Module: huff_pair_encoder

---
 rtl/huff_pair_encoder.sv | 168 ++++++++++++++++
 tb/tb_huff_pair_encoder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/huff_pair_encoder.sv
// Serialises one (x,y) pair per transaction: a codeword from an external table,
// then the optional x linbits/sign and y linbits/sign fields, one bit per cycle.
module huff_pair_encoder #(
  parameter int unsigned LINBITS  = 8,
  parameter int unsigned MAX_BITS = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axiiv,
  input  logic [15:0]         x_val,
  input  logic [15:0]         y_val,
  output logic                axiir,
  output logic [3:0]          lut_x,
  output logic [3:0]          lut_y,
  input  logic [MAX_BITS-1:0] lut_code,
  input  logic [3:0]          lut_len,
  output logic                axiov,
  output logic                axiod,
  output logic                last,
  output logic                sat,
  output logic                err
);

  localparam int unsigned CW = $clog2((MAX_BITS > LINBITS ? MAX_BITS : LINBITS) + 1);
  localparam logic [16:0] MAX_MAG = 17'((32'd1 << LINBITS) + 32'd14);

  // State value k (1..5) owns field-enable bit k-1, so field order is state order.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CODE  = 3'd1;
  localparam logic [2:0] XLIN  = 3'd2;
  localparam logic [2:0] XSIGN = 3'd3;
  localparam logic [2:0] YLIN  = 3'd4;
  localparam logic [2:0] YSIGN = 3'd5;

  logic [2:0]          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [MAX_BITS-1:0] code_q, code_nx;
  logic [3:0]          len_q, len_nx;
  logic [LINBITS-1:0]  xlin_q, xlin_nx, ylin_q, ylin_nx;
  logic                xs_q, xs_nx, ys_q, ys_nx;
  logic [4:0]          en_q, en_nx;
  logic                axiov_nx, axiod_nx, last_nx;

  logic [16:0]         xm, ym, xc, yc;
  logic                len_ok, accept;
  logic [4:0]          en_in;

  function automatic logic [16:0] abs16(input logic [15:0] v);
    logic [16:0] e;
    e = {v[15], v};
    return v[15] ? (~e + 17'd1) : e;
  endfunction

  function automatic logic [2:0] next_after(input logic [2:0] s, input logic [4:0] en);
    logic [2:0] r;
    r = IDLE;
    for (int k = 5; k >= 1; k--) begin
      if (k > int'(s) && en[k-1]) r = 3'(k);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] load_cnt(input logic [2:0] s, input logic [3:0] len);
    case (s)
      CODE:       return CW'(len - 4'd1);
      XLIN, YLIN: return CW'(LINBITS - 1);
      default:    return '0;
    endcase
  endfunction

  function automatic logic bit_at(input logic [2:0] s, input logic [CW-1:0] c,
                                  input logic [MAX_BITS-1:0] code,
                                  input logic [LINBITS-1:0] xl, input logic [LINBITS-1:0] yl,
                                  input logic xs, input logic ys);
    case (s)
      CODE:    return |(code & (MAX_BITS'(1) << c));
      XLIN:    return |(xl & (LINBITS'(1) << c));
      XSIGN:   return xs;
      YLIN:    return |(yl & (LINBITS'(1) << c));
      YSIGN:   return ys;
      default: return 1'b0;
    endcase
  endfunction

  // Input decode: magnitudes, clamping, table indices and field presence.
  always_comb begin
    xm     = abs16(x_val);
    ym     = abs16(y_val);
    xc     = (xm > MAX_MAG) ? MAX_MAG : xm;
    yc     = (ym > MAX_MAG) ? MAX_MAG : ym;
    len_ok = (lut_len != 4'd0) && (32'(lut_len) <= MAX_BITS);
    en_in  = {(y_val != 16'd0), (ym >= 17'd15), (x_val != 16'd0), (xm >= 17'd15), len_ok};
  end

  assign lut_x  = (xm >= 17'd15) ? 4'd15 : xm[3:0];
  assign lut_y  = (ym >= 17'd15) ? 4'd15 : ym[3:0];
  assign axiir  = (state == IDLE) && !rst;
  assign accept = axiiv && axiir;
  assign sat    = accept && ((xm > MAX_MAG) || (ym > MAX_MAG));
  assign err    = accept && !len_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      code_q <= '0;
      len_q  <= '0;
      xlin_q <= '0;
      ylin_q <= '0;
      xs_q   <= 1'b0;
      ys_q   <= 1'b0;
      en_q   <= '0;
      axiov  <= 1'b0;
      axiod  <= 1'b0;
      last   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      code_q <= code_nx;
      len_q  <= len_nx;
      xlin_q <= xlin_nx;
      ylin_q <= ylin_nx;
      xs_q   <= xs_nx;
      ys_q   <= ys_nx;
      en_q   <= en_nx;
      axiov  <= axiov_nx;
      axiod  <= axiod_nx;
      last   <= last_nx;
    end
  end

  // Next state plus look-ahead of the bit the registered outputs present next cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    code_nx  = code_q;
    len_nx   = len_q;
    xlin_nx  = xlin_q;
    ylin_nx  = ylin_q;
    xs_nx    = xs_q;
    ys_nx    = ys_q;
    en_nx    = en_q;

    if (state == IDLE) begin
      if (accept) begin
        code_nx  = lut_code;
        len_nx   = lut_len;
        xlin_nx  = LINBITS'(xc - 17'd15);
        ylin_nx  = LINBITS'(yc - 17'd15);
        xs_nx    = x_val[15];
        ys_nx    = y_val[15];
        en_nx    = en_in;
        state_nx = next_after(IDLE, en_in);
        cnt_nx   = load_cnt(state_nx, lut_len);
      end
    end else if (cnt == '0) begin
      state_nx = next_after(state, en_q);
      cnt_nx   = load_cnt(state_nx, len_q);
    end else begin
      cnt_nx = cnt - CW'(1);
    end

    axiov_nx = (state_nx != IDLE);
    axiod_nx = axiov_nx && bit_at(state_nx, cnt_nx, code_nx, xlin_nx, ylin_nx, xs_nx, ys_nx);
    last_nx  = axiov_nx && (cnt_nx == '0) && (next_after(state_nx, en_nx) == IDLE);
  end

endmodule

// File: tb/tb_huff_pair_encoder.sv
// Directed bench for huff_pair_encoder: hand-computed bit streams per pair.
module tb_huff_pair_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [15:0] x_val, y_val;
  logic        axiir;
  logic [3:0]  lut_x, lut_y;
  logic [11:0] lut_code;
  logic [3:0]  lut_len;
  logic        axiov, axiod, last, sat, err;

  int checks   = 0;
  int failures = 0;

  huff_pair_encoder #(.LINBITS(8), .MAX_BITS(12)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .x_val(x_val), .y_val(y_val),
    .axiir(axiir), .lut_x(lut_x), .lut_y(lut_y), .lut_code(lut_code),
    .lut_len(lut_len), .axiov(axiov), .axiod(axiod), .last(last),
    .sat(sat), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (axiir !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_ready"}, 64'(axiir), 64'd1);
  endtask

  // Offer a pair at a negedge, scramble the inputs after acceptance, then collect bits.
  task automatic run_pair(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [11:0] code, input logic [3:0] len,
                          input logic [3:0] ex_lx, input logic [3:0] ex_ly,
                          input logic ex_sat, input logic ex_err,
                          input int ex_n, input logic [63:0] ex_bits);
    int          n;
    logic [63:0] bits;
    logic        got_last;
    wait_ready(tag);
    axiiv = 1'b1; x_val = x; y_val = y; lut_code = code; lut_len = len;
    #1;
    check_eq({tag, "_lut_x"}, 64'(lut_x), 64'(ex_lx));
    check_eq({tag, "_lut_y"}, 64'(lut_y), 64'(ex_ly));
    check_eq({tag, "_sat"}, 64'(sat), 64'(ex_sat));
    check_eq({tag, "_err"}, 64'(err), 64'(ex_err));
    @(posedge clk);
    #1;
    axiiv = 1'b0; x_val = 16'h7abc; y_val = 16'h8001; lut_code = 12'hfff; lut_len = 4'd7;
    n = 0; bits = '0; got_last = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (axiov !== 1'b1) break;
      bits = {bits[62:0], axiod};
      n++;
      if (last === 1'b1) begin
        got_last = 1'b1;
        break;
      end
    end
    check_eq({tag, "_nbits"}, 64'(n), 64'(ex_n));
    check_eq({tag, "_bits"}, bits, ex_bits);
    check_eq({tag, "_last"}, 64'(got_last), 64'(ex_n > 0));
    @(negedge clk);
    check_eq({tag, "_idle_ov"}, 64'(axiov), 64'd0);
    check_eq({tag, "_idle_rdy"}, 64'(axiir), 64'd1);
  endtask

  initial begin
    rst = 1'b1; axiiv = 1'b0; x_val = '0; y_val = '0; lut_code = '0; lut_len = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_axiov", 64'(axiov), 64'd0);
    check_eq("rst_axiod", 64'(axiod), 64'd0);
    check_eq("rst_last", 64'(last), 64'd0);
    check_eq("rst_sat", 64'(sat), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_rdy", 64'(axiir), 64'd1);

    run_pair("zero",  16'd0,      16'd0,       12'h00f,  4'd4,  4'd0,  4'd0,  1'b0, 1'b0,
             4,  64'b1111);
    run_pair("one",   16'd1,      16'(-1),     12'h00c,  4'd4,  4'd1,  4'd1,  1'b0, 1'b0,
             6,  64'b1100_0_1);
    run_pair("x20",   16'd20,     16'd0,       12'h02b,  4'd8,  4'd15, 4'd0,  1'b0, 1'b0,
             17, 64'b00101011_00000101_0);
    run_pair("clamp", 16'(-300),  16'd15,      12'h003,  4'd4,  4'd15, 4'd15, 1'b1, 1'b0,
             22, 64'b0011_11111111_1_00000000_0);
    run_pair("minint", 16'h8000,  16'd0,       12'h001,  4'd1,  4'd15, 4'd0,  1'b1, 1'b0,
             10, 64'b1_11111111_1);
    run_pair("edge270", 16'd270,  16'(-270),   12'h000,  4'd1,  4'd15, 4'd15, 1'b0, 1'b0,
             19, 64'b0_11111111_0_11111111_1);
    run_pair("b14_15", 16'd14,    16'(-15),    12'h002,  4'd2,  4'd14, 4'd15, 1'b0, 1'b0,
             12, 64'b10_0_00000000_1);
    run_pair("len12", 16'd0,      16'd1,       12'ha5c,  4'd12, 4'd0,  4'd1,  1'b0, 1'b0,
             13, 64'b101001011100_0);
    run_pair("len0",  16'd0,      16'd0,       12'h00f,  4'd0,  4'd0,  4'd0,  1'b0, 1'b1,
             0,  64'd0);
    run_pair("len0f", 16'd1,      16'(-1),     12'h00c,  4'd0,  4'd1,  4'd1,  1'b0, 1'b1,
             2,  64'b01);
    run_pair("len13", 16'd0,      16'd0,       12'hfff,  4'd13, 4'd0,  4'd0,  1'b0, 1'b1,
             0,  64'd0);

    // Abort a 17-bit pair with reset on its third bit.
    wait_ready("abort");
    axiiv = 1'b1; x_val = 16'd20; y_val = 16'd0; lut_code = 12'h02b; lut_len = 4'd8;
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_bit3_ov", 64'(axiov), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_ov", 64'(axiov), 64'd0);
    check_eq("abort_last", 64'(last), 64'd0);
    @(negedge clk);
    check_eq("abort_hold_ov", 64'(axiov), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("abort_rdy", 64'(axiir), 64'd1);
    run_pair("after", 16'd0, 16'd0, 12'h00f, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 4, 64'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
